// File: rtl/adc16_rx.sv
// adc16_rx: periodic reader for a 16-bit SPI ADC. Each frame drops cs_n, issues
// 16 sclk rises (capturing sdi MSB first) and presents the word with a one-cycle dout_valid.
module adc16_rx #(
   parameter int SCLK_DIV      = 2,
   parameter int SAMPLE_PERIOD = 100
) (
   input  logic        clk,
   input  logic        sysrst,
   input  logic        run,
   input  logic        sdi,
   output logic        sclk,
   output logic        cs_n,
   output logic [15:0] dout,
   output logic        dout_valid,
   output logic        busy
);
   localparam int PW = $clog2(SAMPLE_PERIOD);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SETUP = 3'd1;
   localparam logic [2:0] SHIFT = 3'd2;
   localparam logic [2:0] DONE  = 3'd3;
   localparam logic [2:0] WAIT  = 3'd4;

   localparam logic [7:0]    DIV_LAST = 8'(SCLK_DIV - 1);
   localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);

   logic [2:0]    state_q, state_d;
   logic [PW-1:0] per_q, per_d;
   logic [7:0]    div_q, div_d;
   logic [4:0]    hcnt_q, hcnt_d;
   logic [15:0]   shreg_q, shreg_d;
   logic [15:0]   dout_q, dout_d;
   logic          sclk_q, sclk_d;
   logic          cs_n_q, cs_n_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic          per_wrap, div_tick;

   always_comb begin
      per_wrap = (per_q == PER_LAST);
      div_tick = (div_q == DIV_LAST);
      state_d  = state_q;
      per_d    = per_wrap ? '0 : per_q + PW'(1);
      div_d    = div_tick ? '0 : div_q + 8'd1;
      hcnt_d   = hcnt_q;
      shreg_d  = shreg_q;
      sclk_d   = sclk_q;
      dout_d   = dout_q;
      valid_d  = 1'b0;
      case (state_q)
         IDLE: begin
            per_d  = '0;
            div_d  = '0;
            hcnt_d = '0;
            sclk_d = 1'b0;
            if (run) state_d = SETUP;
         end
         SETUP: begin
            // first sclk rise doubles as the capture of bit 15
            if (div_tick) begin
               sclk_d  = 1'b1;
               shreg_d = {shreg_q[14:0], sdi};
               hcnt_d  = 5'd1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (div_tick) begin
               sclk_d = ~sclk_q;
               hcnt_d = hcnt_q + 5'd1;
               if (!sclk_q) shreg_d = {shreg_q[14:0], sdi};
               if (hcnt_q == 5'd31) state_d = DONE;
            end
         end
         DONE: begin
            div_d   = '0;
            dout_d  = shreg_q;
            valid_d = 1'b1;
            if (run) begin
               state_d = WAIT;
            end else begin
               state_d = IDLE;
               per_d   = '0;
            end
         end
         WAIT: begin
            div_d  = '0;
            hcnt_d = '0;
            sclk_d = 1'b0;
            if (!run) begin
               state_d = IDLE;
               per_d   = '0;
            end else if (per_wrap) begin
               state_d = SETUP;
            end
         end
         default: state_d = IDLE;
      endcase
      cs_n_d = !(state_d == SETUP || state_d == SHIFT || state_d == DONE);
      // busy stays up through the cycle dout_valid is presented
      busy_d = !cs_n_d || (state_q == DONE);
   end

   always_ff @(posedge clk or negedge sysrst) begin
      if (!sysrst) begin
         state_q <= IDLE;
         per_q   <= '0;
         div_q   <= '0;
         hcnt_q  <= '0;
         shreg_q <= '0;
         dout_q  <= '0;
         sclk_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         per_q   <= per_d;
         div_q   <= div_d;
         hcnt_q  <= hcnt_d;
         shreg_q <= shreg_d;
         dout_q  <= dout_d;
         sclk_q  <= sclk_d;
         cs_n_q  <= cs_n_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign sclk       = sclk_q;
   assign cs_n       = cs_n_q;
   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign busy       = busy_q;
endmodule

// File: tb/tb_adc16_rx.sv
// Directed bench for adc16_rx: an ADC model shifts table words out MSB first while
// frame timing, period, run-drop and mid-frame reset behaviour are checked.
module tb_adc16_rx;
   logic        clk;
   logic        sysrst;
   logic        run;
   logic        sdi;
   logic        sclk;
   logic        cs_n;
   logic [15:0] dout;
   logic        dout_valid;
   logic        busy;

   logic        sdi_ovr_en;
   logic        sdi_ovr;
   logic        sdi_mdl;
   logic [15:0] adc_word;
   int          bit_idx;
   int          cyc;
   int          sclk_rises;
   int          valid_cnt;
   int          errors;
   int          checks;

   typedef struct {
      logic [15:0] word;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs[6];

   adc16_rx #(.SCLK_DIV(2), .SAMPLE_PERIOD(100)) dut (
      .clk(clk), .sysrst(sysrst), .run(run), .sdi(sdi),
      .sclk(sclk), .cs_n(cs_n), .dout(dout), .dout_valid(dout_valid), .busy(busy)
   );

   assign sdi = sdi_ovr_en ? sdi_ovr : sdi_mdl;

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial sclk_rises = 0;
   always @(posedge sclk) sclk_rises = sclk_rises + 1;

   initial valid_cnt = 0;
   always @(posedge dout_valid) valid_cnt = valid_cnt + 1;

   // ADC model: presents bit 15 when selected, advances one bit after each sclk rise
   initial begin
      bit_idx = 0;
      sdi_mdl = 1'b0;
   end
   always @(negedge cs_n or posedge sclk) begin
      if (!sclk) begin
         bit_idx = 15;
         sdi_mdl = adc_word[15];
      end else if (bit_idx > 0) begin
         bit_idx = bit_idx - 1;
         sdi_mdl = adc_word[bit_idx];
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_fall(output int t0, output int r0, output int v0);
      int n;
      n = 0;
      while (cs_n !== 1'b0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("cs_fall_seen", {31'd0, cs_n}, 32'd0);
      t0 = cyc;
      r0 = sclk_rises;
      v0 = valid_cnt;
   endtask

   task automatic finish_frame(input logic [15:0] exp, input int t0, input int r0, input int v0);
      int n;
      n = 0;
      while (dout_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("valid_latency", cyc - t0, 32'd65);
      check("dout", {16'd0, dout}, {16'd0, exp});
      check("sclk_rises", sclk_rises - r0, 32'd16);
      check("busy_cs_at_valid", {30'd0, busy, cs_n}, 32'd3);
      @(negedge clk);
      check("valid_pulse_count", valid_cnt - v0, 32'd1);
      check("post_valid_low", {30'd0, dout_valid, busy}, 32'd0);
   endtask

   task automatic do_frame(input logic [15:0] exp, output int t0);
      int r0, v0;
      wait_fall(t0, r0, v0);
      finish_frame(exp, t0, r0, v0);
   endtask

   initial begin
      int t0, prev_t0, r0, v0, n, lows, t_rel;
      errors     = 0;
      checks     = 0;
      vecs[0] = '{16'hA5C3, 16'hA5C3};
      vecs[1] = '{16'd699,  16'h02BB};
      vecs[2] = '{16'd0,    16'h0000};
      vecs[3] = '{16'd65535, 16'hFFFF};
      vecs[4] = '{16'hFFFF, 16'hFFFF};
      vecs[5] = '{16'h0000, 16'h0000};

      sysrst     = 1'b1;
      run        = 1'b1;
      sdi_ovr_en = 1'b1;
      sdi_ovr    = 1'b0;
      adc_word   = vecs[0].word;
      #5 sysrst  = 1'b0;

      // held in reset with run high and sdi toggling
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         sdi_ovr = ~sdi_ovr;
         check("reset_outputs", {11'd0, cs_n, sclk, dout, dout_valid, busy, 2'd0}, {11'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0});
      end
      sdi_ovr_en = 1'b0;
      sysrst     = 1'b1;

      // back-to-back frames with run held high
      prev_t0 = 0;
      for (int i = 0; i < 6; i++) begin
         adc_word = vecs[i].word;
         do_frame(vecs[i].exp, t0);
         if (i > 0) check("sample_period", t0 - prev_t0, 32'd100);
         prev_t0 = t0;
      end

      // run dropped after the 5th sclk rise: frame still completes, then idle
      adc_word = 16'h1234;
      wait_fall(t0, r0, v0);
      n = 0;
      while (sclk_rises - r0 < 5 && n < 100) begin
         @(negedge clk);
         n++;
      end
      run = 1'b0;
      finish_frame(16'h1234, t0, r0, v0);
      lows = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (cs_n !== 1'b1 || busy !== 1'b0) lows++;
      end
      check("idle_no_cs_fall", lows, 32'd0);
      check("dout_hold_idle", {16'd0, dout}, 32'h1234);

      // reset at the 8th sclk rise aborts the frame
      adc_word = 16'h0F0F;
      run = 1'b1;
      wait_fall(t0, r0, v0);
      n = 0;
      while (sclk_rises - r0 < 8 && n < 100) begin
         @(negedge clk);
         n++;
      end
      sysrst = 1'b0;
      #1;
      check("midframe_reset_outputs", {cs_n, sclk, dout, dout_valid, busy}, {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
      repeat (5) @(negedge clk);
      check("no_valid_aborted", valid_cnt - v0, 32'd0);
      adc_word = 16'h5A3C;
      sysrst = 1'b1;
      t_rel = cyc;
      do_frame(16'h5A3C, t0);
      check("restart_after_reset", t0 - t_rel, 32'd1);

      // run dropped in WAIT, then reasserted: frame starts on the next edge
      run = 1'b0;
      lows = 0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (cs_n !== 1'b1) lows++;
      end
      check("wait_drop_no_cs", lows, 32'd0);
      adc_word = 16'h8001;
      run = 1'b1;
      @(negedge clk);
      check("restart_immediate", {31'd0, cs_n}, 32'd0);
      do_frame(16'h8001, t0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
